// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle MIPS main control unit (Moore FSM); sequences fetch,
//            decode, execute, memory and write-back, and drives every datapath
//            select and enable. Optional macro MC_CTRL_MEM_WAIT_EN adds
//            MemReady wait states to FETCH, MEMRD and MEMWR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXE   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXE   = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JR     = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_ANDI  = 6'b001100;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_JAL   = 6'b000011;
    localparam logic [5:0] C_FN_JR    = 6'b001000;

    state_t r_state;
    state_t w_next;

    logic w_is_rtype;
    logic w_is_jr;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_imm;
    logic w_is_beq;
    logic w_is_bne;
    logic w_is_j;
    logic w_is_jal;
    logic w_mem_rdy;

    assign w_is_rtype = (Opcode == C_OP_RTYPE);
    assign w_is_jr    = w_is_rtype && (Funct == C_FN_JR);
    assign w_is_lw    = (Opcode == C_OP_LW);
    assign w_is_sw    = (Opcode == C_OP_SW);
    assign w_is_imm   = (Opcode == C_OP_ADDI) || (Opcode == C_OP_ORI) ||
                        (Opcode == C_OP_ANDI) || (Opcode == C_OP_LUI);
    assign w_is_beq   = (Opcode == C_OP_BEQ);
    assign w_is_bne   = (Opcode == C_OP_BNE);
    assign w_is_j     = (Opcode == C_OP_J);
    assign w_is_jal   = (Opcode == C_OP_JAL);

`ifdef MC_CTRL_MEM_WAIT_EN
    assign w_mem_rdy = MemReady;
`else
    // Without wait states every memory access completes in one cycle.
    logic w_unused_memready;
    assign w_unused_memready = MemReady;
    assign w_mem_rdy         = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 3'b000;
        PCSource  = 2'b00;
        IllegalOp = 1'b0;
        State     = r_state;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_mem_rdy;
                PCWrite = w_mem_rdy;
                if (w_mem_rdy) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (w_is_jr) begin
                    w_next = S_JR;
                end else if (w_is_rtype) begin
                    w_next = S_REXE;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEMADR;
                end else if (w_is_imm) begin
                    w_next = S_IEXE;
                end else if (w_is_beq || w_is_bne) begin
                    w_next = S_BRANCH;
                end else if (w_is_j) begin
                    w_next = S_JUMP;
                end else if (w_is_jal) begin
                    w_next = S_JAL;
                end else begin
                    IllegalOp = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = w_is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (w_mem_rdy) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (w_mem_rdy) begin
                    w_next = S_FETCH;
                end
            end
            S_REXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                w_next  = S_ALUWB;
            end
            S_IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Opcode)
                    C_OP_ADDI: ALUOp = 3'b100;
                    C_OP_ORI:  ALUOp = 3'b101;
                    C_OP_ANDI: ALUOp = 3'b010;
                    C_OP_LUI:  ALUOp = 3'b110;
                    default:   ALUOp = 3'b000;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = w_is_rtype ? 2'b01 : 2'b00;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                PCWrite  = (w_is_beq && Zero) || (w_is_bne && !Zero);
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                // Register file latches the already-incremented PC as the link.
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                w_next   = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (reset) begin
            PCWrite   = 1'b0;
            IorD      = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            RegDst    = 2'b00;
            MemtoReg  = 2'b00;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ALUOp     = 3'b000;
            PCSource  = 2'b00;
            IllegalOp = 1'b0;
            State     = 4'd0;
        end
    end

endmodule

`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control unit for the MIPS core. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives the shared ALU through the 3-bit ALUOp code consumed by the ALU control unit, and drives every datapath mux select and write enable. It sits between the instruction register (opcode/funct fields) and the datapath; this lets a single ALU and a single memory port serve all instruction phases.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- Opcode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completion strobe
- PCWrite  out  1  PC enable, unconditional or branch-qualified
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- ALUOp  out  3  000 = add, 001 = sub/branch, 010 = and, 100 = addi, 101 = ori, 110 = lui, 111 = R-type
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs (jr)
- IllegalOp  out  1  one-cycle pulse on an undefined opcode
- State  out  4  current state, for debug

## Operation
- **State encoding:** FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, REXE = 6, ALUWB = 7, IEXE = 8, BRANCH = 9, JUMP = 10, JR = 11, JAL = 12.
- **Outputs are decoded from State only**, except PCWrite in BRANCH (depends on Zero) and IRWrite/PCWrite under the wait feature (see Configuration).
- **Default output values:** every output not listed for a state is 0.
- **FETCH:** MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=000, PCSource=00, PCWrite=1. Next state DECODE.
- **DECODE:** ALUSrcB=11, ALUOp=000; computes the branch target into ALUOut. Next state by Opcode:
  - 000000 with Funct 001000 → JR
  - 000000, any other Funct → REXE
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 001000 / 001101 / 001100 / 001111 (addi / ori / andi / lui) → IEXE
  - 000100 / 000101 (beq / bne) → BRANCH
  - 000010 (j) → JUMP
  - 000011 (jal) → JAL
  - any other opcode → FETCH, with IllegalOp=1 for that DECODE cycle
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEMRD for lw, MEMWR for sw.
- **MEMRD:** MemRead=1, IorD=1. Next state MEMWB.
- **MEMWB:** RegWrite=1, RegDst=00, MemtoReg=01. Next state FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Next state FETCH.
- **REXE:** ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state ALUWB.
- **IEXE:** ALUSrcA=1, ALUSrcB=10. ALUOp = 100 (addi), 101 (ori), 010 (andi), 110 (lui). Next state ALUWB.
- **ALUWB:** RegWrite=1, MemtoReg=00. RegDst = 01 if Opcode = 000000, else 00. Next state FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite = (beq & Zero) | (bne & ~Zero). Next state FETCH.
- **JUMP:** PCSource=10, PCWrite=1. Next state FETCH.
- **JR:** PCSource=11, PCWrite=1. Next state FETCH.
- **JAL:** PCSource=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10. The register file captures the pre-update PC (already PC+4) on the same edge. Next state FETCH.
- **Input stability:** Opcode and Funct must be stable from DECODE until the return to FETCH, because the IR is held in that window.

## Timing
- **Reset:** on any edge with reset=1, State ← FETCH. While reset=1, all outputs are forced to 0, including ALUOp=000, State=0 and IllegalOp=0. Reset mid-instruction aborts it; no writes complete in the reset cycle.
- **First fetch:** the first FETCH cycle is the first cycle after reset deasserts.
- **Cycles per instruction (no wait states):**
  - lw: 5
  - sw, R-type, I-type ALU: 4
  - beq, bne, j, jr, jal: 3
  - illegal opcode: 2
- **Next instruction:** there is no overlap; the next FETCH immediately follows the final state.

## Configuration
- **MC_CTRL_MEM_WAIT_EN defined:**
  - FETCH, MEMRD and MEMWR hold their state until MemReady=1.
  - MemRead/MemWrite and the address selects stay asserted for the whole wait.
  - In FETCH, IRWrite and PCWrite assert only in the cycle where MemReady=1.
  - Each wait cycle adds one cycle to the instruction.
- **Macro undefined:** MemReady is ignored, and each memory state lasts exactly one cycle.

## Test plan
- **Reset:** reset=1 for 2 cycles mid-REXE → State=0, all outputs 0. First cycle after release is FETCH with MemRead=1, IRWrite=1, PCWrite=1.
- **lw (Opcode 100011):** State sequence 0,1,2,3,4,0. MEMRD shows IorD=1. MEMWB shows RegWrite=1, MemtoReg=01.
- **add (Opcode 000000, Funct 100000):** REXE shows ALUOp=111. ALUWB shows RegDst=01, RegWrite=1. Total 4 cycles.
- **Branches:**
  - beq with Zero=1 → PCWrite=1, PCSource=01.
  - beq with Zero=0 → PCWrite=0.
  - bne with Zero=0 → PCWrite=1.
- **Jumps:**
  - jr (000000 / 001000) → State 11, PCSource=11, RegWrite=0.
  - jal → State 12, RegDst=10, MemtoReg=10, PCWrite=1.
  - Opcode 111111 → IllegalOp pulses in DECODE, then FETCH.
- **Wait states (MC_CTRL_MEM_WAIT_EN defined):** MemReady held 0 for 3 cycles in FETCH → State stays 0 and IRWrite=0, while MemRead=1 throughout. IRWrite=1 and PCWrite=1 on the MemReady=1 cycle.
